// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask/data placement, load extraction/extension,
// and detection of misaligned or illegal accesses.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  input  logic        i_we,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_bmask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_illegal
);

  logic [31:0] w_rshift;

  assign w_rshift = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_bmask   = '0;
    o_wdata   = '0;
    o_rdata   = '0;
    o_illegal = 1'b0;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_bmask   = 4'b0001 << i_addr_lo;
        o_wdata   = {4{i_wdata[7:0]}};
        o_rdata   = {{24{w_rshift[7] & ~i_funct3[2]}}, w_rshift[7:0]};
        o_illegal = i_we & i_funct3[2];
      end
      F3_H, F3_HU: begin
        o_bmask   = 4'b0011 << i_addr_lo;
        o_wdata   = {2{i_wdata[15:0]}};
        o_rdata   = {{16{w_rshift[15] & ~i_funct3[2]}}, w_rshift[15:0]};
        o_illegal = i_addr_lo[0] | (i_we & i_funct3[2]);
      end
      F3_W: begin
        o_bmask   = 4'b1111;
        o_wdata   = i_wdata;
        o_rdata   = i_rdata;
        o_illegal = |i_addr_lo;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one req/ack transaction per access on the
// data-memory port, with misalignment faulting and an ack timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_bmask,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e  r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_bmask;
  logic [31:0] r_mem_wdata;
  logic [1:0]  r_addr_lo;
  logic [2:0]  r_funct3;
  logic        r_err;
  logic [31:0] r_rdata;

  logic        w_in_wait;
  logic        w_timeout;
  logic [1:0]  w_sel_lo;
  logic [2:0]  w_sel_f3;
  logic        w_sel_we;
  logic [3:0]  w_bmask;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata_ext;
  logic        w_illegal;

  assign w_in_wait = (r_state == S_WAIT);
  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  // One aligner serves both phases: request fields in IDLE, latched ones in WAIT.
  assign w_sel_lo = w_in_wait ? r_addr_lo : i_addr[1:0];
  assign w_sel_f3 = w_in_wait ? r_funct3  : i_funct3;
  assign w_sel_we = w_in_wait ? r_mem_we  : i_we;

  lsu_align u_align (
    .i_addr_lo (w_sel_lo),
    .i_funct3  (w_sel_f3),
    .i_we      (w_sel_we),
    .i_wdata   (i_wdata),
    .i_rdata   (i_mem_rdata),
    .o_bmask   (w_bmask),
    .o_wdata   (w_wdata),
    .o_rdata   (w_rdata_ext),
    .o_illegal (w_illegal)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_req) w_next = w_illegal ? S_DONE : S_WAIT;
      S_WAIT: if (i_mem_ack || w_timeout) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_bmask <= '0;
      r_mem_wdata <= '0;
      r_addr_lo   <= '0;
      r_funct3    <= '0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= w_illegal;
            if (!w_illegal) begin
              r_mem_we    <= i_we;
              r_mem_addr  <= {i_addr[31:2], 2'b00};
              r_mem_bmask <= w_bmask;
              r_mem_wdata <= w_wdata;
              r_addr_lo   <= i_addr[1:0];
              r_funct3    <= i_funct3;
            end
          end
        end
        S_WAIT: begin
          if (i_mem_ack) begin
            r_rdata <= r_mem_we ? '0 : w_rdata_ext;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_stall     = ~i_reset & (((r_state == S_IDLE) & i_req) | w_in_wait);
  assign o_done      = (r_state == S_DONE);
  assign o_err       = o_done & r_err;
  assign o_rdata     = o_done ? r_rdata : '0;
  assign o_mem_req   = w_in_wait;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_bmask = r_mem_bmask;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus queues expected memory
// requests and completions; monitors compare when the DUT presents them.
module tb_load_store_unit;
  import lsu_pkg::*;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } done_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  bmask;
    logic [31:0] wdata;
  } mem_t;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_req = 1'b0;
  logic        i_we = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic        o_stall, o_done, o_err, o_mem_req, o_mem_we;
  logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = '0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  done_t exp_done_q[$];
  mem_t  exp_mem_q[$];

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req       (i_req),
    .i_we        (i_we),
    .i_funct3    (i_funct3),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_stall     (o_stall),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_rdata     (o_rdata),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_bmask (o_mem_bmask),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Completion monitor
  initial begin
    done_t e;
    forever begin
      @(negedge i_clk);
      if (o_done) begin
        if (exp_done_q.size() == 0) begin
          chk("done_unexpected", 32'(o_done), 32'd0);
        end else begin
          e = exp_done_q.pop_front();
          chk("done_err", 32'(o_err), 32'(e.err));
          chk("done_rdata", o_rdata, e.rdata);
        end
      end
    end
  end

  // Memory request monitor: compares on rise, then checks the outputs hold
  initial begin
    mem_t cur = '0;
    logic prev_req = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_mem_req) begin
        if (!prev_req) begin
          if (exp_mem_q.size() == 0) chk("mem_unexpected", 32'(o_mem_req), 32'd0);
          else cur = exp_mem_q.pop_front();
        end
        chk("mem_we", 32'(o_mem_we), 32'(cur.we));
        chk("mem_addr", o_mem_addr, cur.addr);
        chk("mem_bmask", 32'(o_mem_bmask), 32'(cur.bmask));
        chk("mem_wdata", o_mem_wdata, cur.wdata);
      end
      prev_req = o_mem_req;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Presents one request in an IDLE cycle; returns #1 after the accepting edge.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge i_clk); #1;
    i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
    #1 chk("stall_req", 32'(o_stall), 32'd1);
    @(posedge i_clk); #1;
    i_req = 1'b0; i_we = 1'b0; i_funct3 = '0; i_addr = '0; i_wdata = '0;
  endtask

  // Acks on the k-th WAIT cycle; returns #1 into the DONE cycle.
  task automatic ack_on(input int unsigned k, input logic [31:0] rdata);
    for (int unsigned i = 1; i < k; i++) begin
      chk("stall_wait", 32'(o_stall), 32'd1);
      @(posedge i_clk); #1;
    end
    i_mem_ack = 1'b1; i_mem_rdata = rdata;
    #1 chk("stall_ack", 32'(o_stall), 32'd1);
    @(posedge i_clk); #1;
    i_mem_ack = 1'b0; i_mem_rdata = '0;
    chk("done_latency", 32'(o_done), 32'd1);
    chk("stall_done", 32'(o_stall), 32'd0);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_req"}, 32'(o_mem_req), 32'd0);
    chk({tag, "_we"}, 32'(o_mem_we), 32'd0);
    chk({tag, "_addr"}, o_mem_addr, 32'd0);
    chk({tag, "_bmask"}, 32'(o_mem_bmask), 32'd0);
    chk({tag, "_wdata"}, o_mem_wdata, 32'd0);
    chk({tag, "_done"}, 32'(o_done), 32'd0);
    chk({tag, "_err"}, 32'(o_err), 32'd0);
    chk({tag, "_rdata"}, o_rdata, 32'd0);
  endtask

  initial begin
    // Reset state, with a request present to confirm stall is suppressed
    repeat (2) @(posedge i_clk);
    #1 i_req = 1'b1;
    #1 chk("reset_stall", 32'(o_stall), 32'd0);
    chk_idle_zero("reset");
    i_req = 1'b0;
    @(posedge i_clk); #1 i_reset = 1'b0;

    // LW 0x1004, ack on 3rd WAIT cycle
    exp_mem_q.push_back('{we: 1'b0, addr: 32'h0000_1004, bmask: 4'b1111, wdata: 32'h0});
    exp_done_q.push_back('{err: 1'b0, rdata: 32'hDEAD_BEEF});
    issue(1'b0, F3_W, 32'h0000_1004, 32'h0);
    ack_on(3, 32'hDEAD_BEEF);

    // LB / LBU at byte 3
    exp_mem_q.push_back('{we: 1'b0, addr: 32'h0000_1000, bmask: 4'b1000, wdata: 32'h0});
    exp_done_q.push_back('{err: 1'b0, rdata: 32'hFFFF_FF80});
    issue(1'b0, F3_B, 32'h0000_1003, 32'h0);
    ack_on(2, 32'h80FF_0011);
    exp_mem_q.push_back('{we: 1'b0, addr: 32'h0000_1000, bmask: 4'b1000, wdata: 32'h0});
    exp_done_q.push_back('{err: 1'b0, rdata: 32'h0000_0080});
    issue(1'b0, F3_BU, 32'h0000_1003, 32'h0);
    ack_on(1, 32'h80FF_0011);

    // LH / LHU upper half
    exp_mem_q.push_back('{we: 1'b0, addr: 32'h0000_1000, bmask: 4'b1100, wdata: 32'h0});
    exp_done_q.push_back('{err: 1'b0, rdata: 32'hFFFF_80FF});
    issue(1'b0, F3_H, 32'h0000_1002, 32'h0);
    ack_on(1, 32'h80FF_0011);
    exp_mem_q.push_back('{we: 1'b0, addr: 32'h0000_1000, bmask: 4'b1100, wdata: 32'h0});
    exp_done_q.push_back('{err: 1'b0, rdata: 32'h0000_80FF});
    issue(1'b0, F3_HU, 32'h0000_1002, 32'h0);
    ack_on(1, 32'h80FF_0011);

    // SH 0x2002, ack in first WAIT cycle: done two cycles after request
    exp_mem_q.push_back('{we: 1'b1, addr: 32'h0000_2000, bmask: 4'b1100, wdata: 32'hABCD_ABCD});
    exp_done_q.push_back('{err: 1'b0, rdata: 32'h0});
    issue(1'b1, F3_H, 32'h0000_2002, 32'h1234_ABCD);
    ack_on(1, 32'h5555_5555);

    // SB 0x1001
    exp_mem_q.push_back('{we: 1'b1, addr: 32'h0000_1000, bmask: 4'b0010, wdata: 32'hA5A5_A5A5});
    exp_done_q.push_back('{err: 1'b0, rdata: 32'h0});
    issue(1'b1, F3_B, 32'h0000_1001, 32'h0000_00A5);
    ack_on(2, 32'h0);

    // Misaligned LW, illegal funct3, store with funct3[2]=1: immediate error
    exp_done_q.push_back('{err: 1'b1, rdata: 32'h0});
    issue(1'b0, F3_W, 32'h0000_1001, 32'h0);
    chk("misalign_done", 32'(o_done), 32'd1);
    chk("misalign_req", 32'(o_mem_req), 32'd0);
    exp_done_q.push_back('{err: 1'b1, rdata: 32'h0});
    issue(1'b0, 3'b011, 32'h0000_1000, 32'h0);
    exp_done_q.push_back('{err: 1'b1, rdata: 32'h0});
    issue(1'b1, F3_BU, 32'h0000_1000, 32'h0);

    // Timeout: four WAIT cycles, then error on the fifth cycle after acceptance
    exp_mem_q.push_back('{we: 1'b0, addr: 32'h0000_3000, bmask: 4'b1111, wdata: 32'h0});
    exp_done_q.push_back('{err: 1'b1, rdata: 32'h0});
    issue(1'b0, F3_W, 32'h0000_3000, 32'h0);
    for (int unsigned i = 0; i < 4; i++) begin
      chk("to_req_high", 32'(o_mem_req), 32'd1);
      chk("to_no_done", 32'(o_done), 32'd0);
      @(posedge i_clk); #1;
    end
    chk("to_done", 32'(o_done), 32'd1);
    chk("to_err", 32'(o_err), 32'd1);

    // Ack on the last WAIT cycle beats the timeout
    exp_mem_q.push_back('{we: 1'b0, addr: 32'h0000_3000, bmask: 4'b1111, wdata: 32'h0});
    exp_done_q.push_back('{err: 1'b0, rdata: 32'h1234_5678});
    issue(1'b0, F3_W, 32'h0000_3000, 32'h0);
    ack_on(4, 32'h1234_5678);

    // Reset in the second WAIT cycle, then a stray ack; no completion expected
    exp_mem_q.push_back('{we: 1'b0, addr: 32'h0000_4000, bmask: 4'b1111, wdata: 32'h0});
    issue(1'b0, F3_W, 32'h0000_4000, 32'h0);
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    #1 chk("rst_mid_stall", 32'(o_stall), 32'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFF_FFFF;
    chk_idle_zero("rst_mid");
    @(posedge i_clk); #1;
    i_mem_ack = 1'b0; i_mem_rdata = '0;
    chk("rst_stray_ack_done", 32'(o_done), 32'd0);
    chk("rst_stray_ack_req", 32'(o_mem_req), 32'd0);

    // Normal access after reset
    exp_mem_q.push_back('{we: 1'b0, addr: 32'h0000_4000, bmask: 4'b1111, wdata: 32'h0});
    exp_done_q.push_back('{err: 1'b0, rdata: 32'hCAFE_F00D});
    issue(1'b0, F3_W, 32'h0000_4000, 32'h0);
    ack_on(2, 32'hCAFE_F00D);

    repeat (4) @(posedge i_clk);
    #1;
    chk("done_q_drained", exp_done_q.size(), 32'd0);
    chk("mem_q_drained", exp_mem_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit downstream of the execute-stage ALU. It takes the ALU result as the effective address and runs one request/acknowledge transaction on the data-memory port. Store data is byte-lane aligned and masked; load data is extracted and sign- or zero-extended to 32 bits. The core is stalled until the access completes, faults on misalignment, or times out.

## Interface
- TIMEOUT_CYCLES, default 255: maximum number of WAIT cycles without `i_mem_ack` before the access aborts; legal range 1..65535.
- i_clk  in  1  clock; everything is sampled on the rising edge.
- i_reset  in  1  synchronous reset, active high.
- i_req  in  1  load/store request from the core; sampled only in IDLE.
- i_we  in  1  1 = store, 0 = load.
- i_funct3  in  3  RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- i_addr  in  32  effective address (ALU result).
- i_wdata  in  32  store data (rs2).
- o_stall  out  1  core must hold its PC and operands while this is high.
- o_done  out  1  one-cycle pulse; the access is finished.
- o_err  out  1  qualified by o_done; misaligned, illegal funct3, or timeout.
- o_rdata  out  32  load result; valid when o_done=1, otherwise 0.
- o_mem_req  out  1  memory request; held high until acknowledged.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  32  word-aligned address ({i_addr[31:2],2'b00}).
- o_mem_bmask  out  4  byte enables; bit k enables byte k.
- o_mem_wdata  out  32  store data shifted into its byte lanes.
- i_mem_ack  in  1  memory acknowledge; sampled only while o_mem_req=1.
- i_mem_rdata  in  32  read word; valid in the cycle i_mem_ack=1.

## Operation
- The FSM has three states: IDLE, WAIT, DONE.
- **IDLE, legal i_req:**
  - Latch address, we, funct3, lane-shifted wdata and bmask.
  - Go to WAIT.
- **IDLE, illegal i_req:** go to DONE with the error flag set; no memory access is made. An access is illegal when:
  - halfword and addr[0]=1, or
  - word and addr[1:0]≠0, or
  - funct3 ∈ {011,110,111}, or
  - store with funct3[2]=1.
- **WAIT:**
  - o_mem_req=1 and all memory outputs are stable from registers.
  - A timeout counter starts at 0 and increments every WAIT cycle.
  - i_mem_ack=1: capture the extracted/extended load data (stores capture 0) and go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 with no ack: go to DONE with err=1 and data 0.
  - If ack and timeout occur in the same cycle, the ack wins.
- **DONE:**
  - o_done=1, o_err=flag, o_rdata=captured data.
  - Return to IDLE unconditionally.
  - An i_req present in DONE is not accepted; the core re-presents it in the next IDLE cycle.
- **Byte-lane rules:**
  - Byte: bmask = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - Half: bmask = 0011 << addr[1:0]; wdata = {2{wdata[15:0]}}.
  - Word: bmask = 1111.
  - Loads: select the byte/half at addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
  - Load bmask equals the access mask (informational only).
- **Stall:**
  - o_stall = (IDLE & i_req) | WAIT.
  - Combinational, so the core stalls in the same cycle it presents a request; this includes requests that will fault.
- **Reset** (mid-operation included): state IDLE, counter 0, o_mem_req/we/bmask/wdata/addr all 0, o_done=0, o_err=0, o_rdata=0, o_stall=0 during reset. An ack arriving after reset is ignored.

## Timing
- Request accepted at edge N; o_mem_req is high from cycle N+1.
- Ack in cycle M (M ≥ N+1) → o_done pulse in cycle M+1 → IDLE at M+2.
- Minimum load/store latency: 2 cycles from request to done; one request can be accepted every 3 cycles.
- Misaligned or illegal request: o_done=o_err=1 in cycle N+1; o_mem_req never rises.
- Timeout: o_done=o_err=1 exactly TIMEOUT_CYCLES+1 cycles after acceptance.
- Memory outputs change only on state entry; they never glitch while o_mem_req=1.

## Structure
- **Shared package `lsu_pkg`:**
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum lsu_state_e {S_IDLE, S_WAIT, S_DONE}.
- **Sub-module `lsu_align`** (combinational): addr[1:0] + funct3 + wdata/rdata → bmask, shifted wdata, extended rdata, misaligned/illegal flag. Instantiated once.
- Counter width: $clog2(TIMEOUT_CYCLES+1).

## Test plan
- **LW:** LW addr 0x0000_1004, ack after 3 cycles with rdata 0xDEAD_BEEF → o_mem_addr 0x1004, bmask 1111; o_done at ack+1 with o_rdata 0xDEAD_BEEF, err 0; o_stall high from request cycle through the ack cycle.
- **LB/LBU:** LB addr 0x1003 and LBU addr 0x1003, rdata 0x80FF_0011 → LB returns 0xFFFF_FF80, LBU returns 0x0000_0080; bmask 1000.
- **SH:** SH addr 0x2002, wdata 0x1234_ABCD, ack in first WAIT cycle → o_mem_we 1, bmask 1100, o_mem_wdata 0xABCD_ABCD, o_done 2 cycles after request.
- **Misaligned:** LW addr 0x1001 → o_mem_req stays 0; next cycle o_done=1, o_err=1, o_rdata 0.
- **Timeout:** TIMEOUT_CYCLES=4, no ack → o_mem_req high 4 cycles; o_done/o_err at cycle 5 after acceptance. Repeat with ack on the 4th WAIT cycle → err 0.
- **Reset mid-WAIT:** i_reset in the 2nd WAIT cycle, then ack → all outputs 0 next cycle; no o_done pulse. A new request after reset completes normally.
